// File: rtl/corefifo_gray_ptr_sync_pkg.sv
// -----------------------------------------------------------------------------
// corefifo_gray_ptr_sync_pkg
//   Shared constants and Gray-code helpers for the FIFO pointer synchroniser.
//   The helpers work on a fixed 32-bit word. Callers zero-extend narrower
//   pointers into that word. Leading zeros do not change gray2bin, bin2gray
//   or popcnt_gt1, so one set of functions serves every pointer width.
// -----------------------------------------------------------------------------
package corefifo_gray_ptr_sync_pkg;

   // Fewest synchroniser flops that still gives metastability settling time.
   localparam int MIN_SYNC_STAGES = 2;

   // Width of the helper word; pointers wider than this are not supported.
   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b = '0;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary to Gray: neighbouring codes differ in exactly one bit.
   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // True when more than one bit is set. Clearing the lowest set bit
   // leaves a non-zero word only if a second bit was set.
   function automatic logic popcnt_gt1(input ptr_word_t x);
      return (x & (x - ptr_word_t'(1'b1))) != ptr_word_t'(1'b0);
   endfunction

endpackage

// File: rtl/corefifo_gray_ptr_sync_if.sv
// -----------------------------------------------------------------------------
// corefifo_gray_ptr_sync_if
//   Bundles the pointer-synchroniser data signals.
//   master : pointer source / flag logic side (drives inp, err_clr)
//   slave  : the synchroniser itself (drives the synchronised results)
//   Signals (W = ADDRWIDTH+1):
//     inp       NUM_CH*W  Gray pointers from the source domain, ch c at [c*W +: W]
//     err_clr   NUM_CH    clear sticky err_multi per channel
//     sync_gray NUM_CH*W  synchronised Gray pointers
//     sync_bin  NUM_CH*W  registered binary form of sync_gray
//     bin_vld   1         pipeline filled since last reset
//     chg       NUM_CH    one-cycle strobe when sync_bin of a channel changes
//     err_multi NUM_CH    sticky multi-bit Gray change flag
// -----------------------------------------------------------------------------
interface corefifo_gray_ptr_sync_if #(
   parameter int ADDRWIDTH = 3,
   parameter int NUM_CH    = 1
);
   localparam int W = ADDRWIDTH + 1;

   logic [NUM_CH*W-1:0] inp;
   logic [NUM_CH-1:0]   err_clr;
   logic [NUM_CH*W-1:0] sync_gray;
   logic [NUM_CH*W-1:0] sync_bin;
   logic                bin_vld;
   logic [NUM_CH-1:0]   chg;
   logic [NUM_CH-1:0]   err_multi;

   modport master (
      output inp,
      output err_clr,
      input  sync_gray,
      input  sync_bin,
      input  bin_vld,
      input  chg,
      input  err_multi
   );

   modport slave (
      input  inp,
      input  err_clr,
      output sync_gray,
      output sync_bin,
      output bin_vld,
      output chg,
      output err_multi
   );
endinterface

// File: rtl/corefifo_gray_ptr_sync_ch.sv
// -----------------------------------------------------------------------------
// corefifo_ptr_sync_ch
//   One pointer channel. It contains the synchroniser stage chain, the
//   binary-converted output register, the change strobe and the optional
//   multi-bit-change checker.
//   Ports (W = ADDRWIDTH+1):
//     clk, arstn, srstn  clock, async / sync active-low resets
//     bin_vld            shared "pipeline filled" qualifier from the top
//     inp        [W]     Gray pointer from the foreign domain
//     err_clr            clear request for err_multi
//     sync_gray  [W]     last synchroniser stage
//     sync_bin   [W]     registered binary of sync_gray
//     chg                sync_bin changed on this edge (only once bin_vld is 1)
//     err_multi          sticky: consecutive sync_gray samples differ in >1 bit
// -----------------------------------------------------------------------------
module corefifo_ptr_sync_ch
   import corefifo_gray_ptr_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int ADDRWIDTH  = 3,
   parameter int CHK_EN     = 1,
   localparam int W         = ADDRWIDTH + 1
) (
   input  logic         clk,
   input  logic         arstn,
   input  logic         srstn,
   input  logic         bin_vld,
   input  logic [W-1:0] inp,
   input  logic         err_clr,
   output logic [W-1:0] sync_gray,
   output logic [W-1:0] sync_bin,
   output logic         chg,
   output logic         err_multi
);

   logic [W-1:0] stage_q [NUM_STAGES];
   logic [W-1:0] stage_d [NUM_STAGES];
   logic [W-1:0] bin_q;
   logic [W-1:0] bin_d;
   logic         chg_q;
   logic         chg_d;
   logic [W-1:0] bin_next_s;

   // Binary form of the current last stage; this is what bin_q loads next.
   always_comb begin
      bin_next_s = W'(gray2bin(PTR_MAX_W'(stage_q[NUM_STAGES-1])));
   end

   // Next state for the stage chain, binary register and change strobe.
   always_comb begin
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_d[i] = '0;
      end
      bin_d = '0;
      chg_d = 1'b0;
      if (srstn) begin
         stage_d[0] = inp;
         for (int i = 1; i < NUM_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
         end
         bin_d = bin_next_s;
         // The strobe is suppressed while the pipeline is still filling.
         chg_d = bin_vld && (bin_next_s != bin_q);
      end else begin
         // Synchronous reset discards everything in flight.
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_d[i] = '0;
         end
         bin_d = '0;
         chg_d = 1'b0;
      end
   end

   // Stage chain, binary register and change-strobe flops.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         bin_q <= '0;
         chg_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
         bin_q <= bin_d;
         chg_q <= chg_d;
      end
   end

   assign sync_gray = stage_q[NUM_STAGES-1];
   assign sync_bin  = bin_q;
   assign chg       = chg_q;

   generate
      if (CHK_EN != 0) begin : g_chk
         logic [W-1:0] last_gray_q;
         logic [W-1:0] last_gray_d;
         logic         err_q;
         logic         err_d;
         logic         multi_s;

         // Checker next state: remember the previous sample and latch
         // multi-bit jumps. A set wins over a clear in the same cycle.
         always_comb begin
            multi_s     = popcnt_gt1(PTR_MAX_W'(stage_q[NUM_STAGES-1] ^ last_gray_q));
            last_gray_d = '0;
            err_d       = 1'b0;
            if (srstn) begin
               last_gray_d = stage_q[NUM_STAGES-1];
               err_d       = (bin_vld && multi_s) || (err_q && !err_clr);
            end else begin
               last_gray_d = '0;
               err_d       = 1'b0;
            end
         end

         // Checker flops.
         always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
               last_gray_q <= '0;
               err_q       <= 1'b0;
            end else begin
               last_gray_q <= last_gray_d;
               err_q       <= err_d;
            end
         end

         assign err_multi = err_q;
      end else begin : g_no_chk
         assign err_multi = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/corefifo_gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// corefifo_gray_ptr_sync
//   Multi-channel N-stage synchroniser for Gray-coded FIFO pointers.
//   It brings pointers from a foreign clock domain into clk. For each
//   channel it delivers the Gray value, a registered binary value, a change
//   strobe and a sticky multi-bit-change error. One fill counter is shared
//   by all channels; it raises bin_vld once the pipeline holds real data.
//   Ports:
//     clk    destination-domain clock
//     arstn  asynchronous active-low reset
//     srstn  synchronous active-low reset
//     bus    corefifo_gray_ptr_sync_if.slave (inp, err_clr in; sync_gray,
//            sync_bin, bin_vld, chg, err_multi out)
// -----------------------------------------------------------------------------
module corefifo_gray_ptr_sync
   import corefifo_gray_ptr_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int ADDRWIDTH  = 3,
   parameter int NUM_CH     = 1,
   parameter int CHK_EN     = 1
) (
   input  logic                     clk,
   input  logic                     arstn,
   input  logic                     srstn,
   corefifo_gray_ptr_sync_if.slave  bus
);

   localparam int W      = ADDRWIDTH + 1;
   localparam int FILL_W = $clog2(NUM_STAGES + 2);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(NUM_STAGES + 1);

   generate
      if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
         $error("corefifo_gray_ptr_sync: NUM_STAGES must be >= 2");
      end
      if (NUM_CH < 1) begin : g_bad_ch
         $error("corefifo_gray_ptr_sync: NUM_CH must be >= 1");
      end
   endgenerate

   logic [FILL_W-1:0]   fill_q;
   logic [FILL_W-1:0]   fill_d;
   logic                bin_vld_q;
   logic                bin_vld_d;
   logic [NUM_CH*W-1:0] sync_gray_s;
   logic [NUM_CH*W-1:0] sync_bin_s;
   logic [NUM_CH-1:0]   chg_s;
   logic [NUM_CH-1:0]   err_s;

   // Fill counter: counts edges since reset release and saturates once the
   // stage chain and binary register both hold post-reset data.
   always_comb begin
      fill_d    = '0;
      bin_vld_d = 1'b0;
      if (srstn) begin
         if (fill_q == FILL_MAX) begin
            fill_d = fill_q;
         end else begin
            fill_d = fill_q + FILL_W'(1'b1);
         end
         bin_vld_d = (fill_d == FILL_MAX);
      end else begin
         fill_d    = '0;
         bin_vld_d = 1'b0;
      end
   end

   // Fill counter and bin_vld flops.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         fill_q    <= '0;
         bin_vld_q <= 1'b0;
      end else begin
         fill_q    <= fill_d;
         bin_vld_q <= bin_vld_d;
      end
   end

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         corefifo_ptr_sync_ch #(
            .NUM_STAGES (NUM_STAGES),
            .ADDRWIDTH  (ADDRWIDTH),
            .CHK_EN     (CHK_EN)
         ) u_ch (
            .clk        (clk),
            .arstn      (arstn),
            .srstn      (srstn),
            .bin_vld    (bin_vld_q),
            .inp        (bus.inp[c*W +: W]),
            .err_clr    (bus.err_clr[c]),
            .sync_gray  (sync_gray_s[c*W +: W]),
            .sync_bin   (sync_bin_s[c*W +: W]),
            .chg        (chg_s[c]),
            .err_multi  (err_s[c])
         );
      end
   endgenerate

   assign bus.sync_gray = sync_gray_s;
   assign bus.sync_bin  = sync_bin_s;
   assign bus.bin_vld   = bin_vld_q;
   assign bus.chg       = chg_s;
   assign bus.err_multi = err_s;

endmodule
